// File: rtl/vga_output_stage.sv
// Final VGA pixel stage: delay-matches controller timing to the pixel source, applies
// blanking and frame-synchronous test-pattern selection, and drives the registered pins.
module vga_output_stage #(
    parameter int COLOR_BITS  = 4,
    parameter int COL_W       = 10,
    parameter int ROW_W       = 9,
    parameter int H_ACTIVE    = 640,
    parameter int PIPE_DEPTH  = 2,
    parameter int SYNC_INVERT = 0,
    parameter int SYNC_IDLE   = 1,
    parameter int GRID_LOG2   = 4,
    parameter int FC_W        = 16
) (
    input  logic                    pixel_clk,
    input  logic                    reset_n,
    input  logic                    h_sync_in,
    input  logic                    v_sync_in,
    input  logic                    disp_ena_in,
    input  logic [COL_W-1:0]        column,
    input  logic [ROW_W-1:0]        row,
    input  logic [COLOR_BITS-1:0]   src_r,
    input  logic [COLOR_BITS-1:0]   src_g,
    input  logic [COLOR_BITS-1:0]   src_b,
    input  logic [1:0]              mode_sel,
    input  logic [3*COLOR_BITS-1:0] fill_rgb,
    output logic [COLOR_BITS-1:0]   vga_r,
    output logic [COLOR_BITS-1:0]   vga_g,
    output logic [COLOR_BITS-1:0]   vga_b,
    output logic                    vga_hs,
    output logic                    vga_vs,
    output logic                    frame_start,
    output logic [FC_W-1:0]         frame_count
);

    localparam logic SYNC_INV_B = 1'(SYNC_INVERT);
    localparam logic SYNC_IDL_B = 1'(SYNC_IDLE);
    localparam logic SYNC_RST   = SYNC_IDL_B ^ SYNC_INV_B;
    localparam int   BAR_PX     = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             de;
        logic             fs;
        logic [1:0]       mode;
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
    } tag_t;

    localparam tag_t TAG_RST = '{hs: SYNC_RST, vs: SYNC_RST, de: 1'b0, fs: 1'b0,
                                 mode: 2'd0, col: '0, row: '0};

    logic       fs_in;
    logic [1:0] mode_act;
    tag_t       in_tag;
    tag_t       tail;

    assign fs_in = disp_ena_in && (column == '0) && (row == '0);

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_act <= 2'd0;
        end else if (fs_in) begin
            mode_act <= mode_sel;
        end
    end

    // The frame-start pixel already carries the newly selected mode.
    always_comb begin
        in_tag.hs   = h_sync_in;
        in_tag.vs   = v_sync_in;
        in_tag.de   = disp_ena_in;
        in_tag.fs   = fs_in;
        in_tag.mode = fs_in ? mode_sel : mode_act;
        in_tag.col  = column;
        in_tag.row  = row;
    end

    generate
        if (PIPE_DEPTH == 0) begin : g_nopipe
            assign tail = in_tag;
        end else begin : g_pipe
            tag_t stg [PIPE_DEPTH];

            always_ff @(posedge pixel_clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < PIPE_DEPTH; i++) stg[i] <= TAG_RST;
                end else begin
                    stg[0] <= in_tag;
                    for (int i = 1; i < PIPE_DEPTH; i++) stg[i] <= stg[i-1];
                end
            end

            assign tail = stg[PIPE_DEPTH-1];
        end
    endgenerate

    logic [COL_W-1:0]      bar_q;
    logic [2:0]            bar_idx;
    logic [2:0]            bar_k;
    logic                  grid_hit;
    logic [COLOR_BITS-1:0] pix_r;
    logic [COLOR_BITS-1:0] pix_g;
    logic [COLOR_BITS-1:0] pix_b;

    assign bar_q    = tail.col / COL_W'(BAR_PX);
    assign bar_idx  = (bar_q > COL_W'(7)) ? 3'd7 : bar_q[2:0];
    assign bar_k    = 3'd7 - bar_idx;
    assign grid_hit = (tail.col[GRID_LOG2-1:0] == '0) || (tail.row[GRID_LOG2-1:0] == '0);

    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        if (tail.de) begin
            case (tail.mode)
                2'd0: begin
                    pix_r = src_r;
                    pix_g = src_g;
                    pix_b = src_b;
                end
                2'd1: begin
                    pix_r = fill_rgb[3*COLOR_BITS-1 -: COLOR_BITS];
                    pix_g = fill_rgb[2*COLOR_BITS-1 -: COLOR_BITS];
                    pix_b = fill_rgb[COLOR_BITS-1:0];
                end
                2'd2: begin
                    pix_r = {COLOR_BITS{bar_k[2]}};
                    pix_g = {COLOR_BITS{bar_k[1]}};
                    pix_b = {COLOR_BITS{bar_k[0]}};
                end
                default: begin
                    pix_r = grid_hit ? '1 : src_r;
                    pix_g = grid_hit ? '1 : src_g;
                    pix_b = grid_hit ? '1 : src_b;
                end
            endcase
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= SYNC_IDL_B;
            vga_vs      <= SYNC_IDL_B;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            vga_r       <= pix_r;
            vga_g       <= pix_g;
            vga_b       <= pix_b;
            vga_hs      <= tail.hs ^ SYNC_INV_B;
            vga_vs      <= tail.vs ^ SYNC_INV_B;
            frame_start <= tail.fs;
            if (tail.fs) frame_count <= frame_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_output_stage.sv
// Directed bench for vga_output_stage: default build plus an inverted-sync, 2-bit-counter build
// driven from the same stimulus and a 2-cycle-latency pixel source model.
module tb_vga_output_stage;

    logic        pixel_clk = 1'b0;
    logic        reset_n;
    logic        h_sync_in, v_sync_in, disp_ena_in;
    logic [9:0]  column;
    logic [8:0]  row;
    logic [3:0]  src_r, src_g, src_b;
    logic [1:0]  mode_sel;
    logic [11:0] fill_rgb;
    logic        src_white;

    logic [3:0]  r0, g0, b0, r1, g1, b1;
    logic        hs0, vs0, fs0, hs1, vs1, fs1;
    logic [15:0] fc0;
    logic [1:0]  fc1;

    logic [11:0] sp1, sp2;

    int tests = 0;
    int fails = 0;

    int          bar_col [8] = '{0, 79, 80, 159, 160, 559, 560, 639};
    logic [11:0] bar_exp [8] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'hFF0,
                                 12'hF0F, 12'h00F, 12'h000, 12'h000};

    always #5 pixel_clk = ~pixel_clk;

    // Pixel source: returns {col[3:0], row[3:0], ~col[3:0]} two clocks after the coordinate.
    always @(posedge pixel_clk) begin
        sp1 <= {column[3:0], row[3:0], ~column[3:0]};
        sp2 <= sp1;
    end
    assign {src_r, src_g, src_b} = src_white ? 12'hFFF : sp2;

    vga_output_stage dut0 (
        .pixel_clk(pixel_clk), .reset_n(reset_n),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .disp_ena_in(disp_ena_in),
        .column(column), .row(row),
        .src_r(src_r), .src_g(src_g), .src_b(src_b),
        .mode_sel(mode_sel), .fill_rgb(fill_rgb),
        .vga_r(r0), .vga_g(g0), .vga_b(b0),
        .vga_hs(hs0), .vga_vs(vs0),
        .frame_start(fs0), .frame_count(fc0)
    );

    vga_output_stage #(.SYNC_INVERT(1), .FC_W(2)) dut1 (
        .pixel_clk(pixel_clk), .reset_n(reset_n),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .disp_ena_in(disp_ena_in),
        .column(column), .row(row),
        .src_r(src_r), .src_g(src_g), .src_b(src_b),
        .mode_sel(mode_sel), .fill_rgb(fill_rgb),
        .vga_r(r1), .vga_g(g1), .vga_b(b1),
        .vga_hs(hs1), .vga_vs(vs1),
        .frame_start(fs1), .frame_count(fc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_px(input string tag, input logic [11:0] rgb, input logic fs);
        chk({tag, "_rgb"}, {20'd0, r0, g0, b0}, {20'd0, rgb});
        chk({tag, "_fs"}, {31'd0, fs0}, {31'd0, fs});
    endtask

    task automatic pix(input logic hs, input logic vs, input logic de, input int col, input int rw);
        h_sync_in   = hs;
        v_sync_in   = vs;
        disp_ena_in = de;
        column      = col[9:0];
        row         = rw[8:0];
        @(posedge pixel_clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; h_sync_in = 1'b1; v_sync_in = 1'b1; disp_ena_in = 1'b0;
        column = '0; row = '0; mode_sel = 2'd0; fill_rgb = 12'h000; src_white = 1'b0;
        repeat (3) @(posedge pixel_clk);
        #1;

        chk("rst_rgb", {20'd0, r0, g0, b0}, 32'h0);
        chk("rst_hs", {31'd0, hs0}, 32'd1);
        chk("rst_vs", {31'd0, vs0}, 32'd1);
        chk("rst_fs", {31'd0, fs0}, 32'd0);
        chk("rst_fc", {16'd0, fc0}, 32'd0);
        chk("rst_inv_hs", {31'd0, hs1}, 32'd1);
        chk("rst_inv_vs", {31'd0, vs1}, 32'd1);
        chk("rst_inv_rgb", {20'd0, r1, g1, b1}, 32'h0);

        // Release: inverted pins stay at idle until real timing has flushed through.
        reset_n = 1'b1;
        pix(1, 1, 0, 0, 0);
        pix(1, 1, 0, 0, 0);
        chk("inv_hold", {31'd0, hs1}, 32'd1);
        pix(1, 1, 0, 0, 0);
        chk("inv_hs", {31'd0, hs1}, 32'd0);
        chk("inv_vs", {31'd0, vs1}, 32'd0);
        chk("hs_plain", {31'd0, hs0}, 32'd1);

        // Frame 1, mode 0: pixel c appears two pix() calls later (3 clocks after drive).
        for (int c = 0; c < 10; c++) begin
            pix(1, 1, 1, c, 0);
            if (c >= 2) begin
                chk("a_r", {28'd0, r0}, 32'(c - 2));
                chk("a_g", {28'd0, g0}, 32'd0);
                chk("a_b", {28'd0, b0}, 32'(15 - (c - 2)));
                chk("a_fs", {31'd0, fs0}, {31'd0, c == 2});
            end
            if (c == 2) begin
                chk("a_fc0", {16'd0, fc0}, 32'd1);
                chk("a_fc1", {30'd0, fc1}, 32'd1);
            end
        end

        // Blanking with a white source: rgb forced to 0, sync still passes through.
        src_white = 1'b1;
        for (int j = 0; j < 11; j++) begin
            pix((j >= 2 && j < 5) ? 1'b0 : 1'b1, 1, 0, 10 + j, 0);
            if (j >= 2) begin
                chk("b_rgb", {20'd0, r0, g0, b0}, 32'h0);
                chk("b_hs", {31'd0, hs0}, {31'd0, ((j - 2) >= 2 && (j - 2) < 5) ? 1'b0 : 1'b1});
                chk("b_hs_inv", {31'd0, hs1}, {31'd0, ((j - 2) >= 2 && (j - 2) < 5) ? 1'b1 : 1'b0});
            end
        end
        src_white = 1'b0;

        // Frame 2, colour bars; a mid-frame mode_sel change must not take effect.
        mode_sel = 2'd2;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) mode_sel = 2'd1;
            if (i < 8) pix(1, 1, 1, bar_col[i], 0);
            else       pix(1, 1, 0, 0, 1);
            if (i >= 2) chk_px("bars", bar_exp[i-2], i == 2);
            if (i == 2) begin
                chk("c_fc0", {16'd0, fc0}, 32'd2);
                chk("c_fc1", {30'd0, fc1}, 32'd2);
            end
        end

        // Frame 3 in mode 0, switch request at row 100; frame 4 must be fill.
        mode_sel = 2'd0;
        fill_rgb = 12'h357;
        pix(1, 1, 1, 0, 0);
        pix(1, 1, 1, 1, 0);
        mode_sel = 2'd1;
        pix(1, 1, 1, 5, 100);
        chk_px("d_f3_p0", 12'h00F, 1'b1);
        chk("d_fc0", {16'd0, fc0}, 32'd3);
        chk("d_fc1", {30'd0, fc1}, 32'd3);
        pix(1, 1, 1, 6, 100);
        chk_px("d_f3_p1", 12'h10E, 1'b0);
        pix(1, 1, 0, 7, 100);
        chk_px("d_r100_c5", 12'h54A, 1'b0);
        pix(1, 1, 1, 0, 0);
        chk_px("d_r100_c6", 12'h649, 1'b0);
        pix(1, 1, 1, 1, 0);
        chk_px("d_blank", 12'h000, 1'b0);
        pix(1, 1, 0, 2, 0);
        chk_px("d_f4_p0", 12'h357, 1'b1);
        chk("d_fc0_b", {16'd0, fc0}, 32'd4);
        chk("d_fc1_wrap", {30'd0, fc1}, 32'd0);
        pix(1, 1, 0, 0, 1);
        chk_px("d_f4_p1", 12'h357, 1'b0);
        pix(1, 1, 0, 0, 1);
        chk_px("d_f4_blank", 12'h000, 1'b0);

        // Frame 5, grid overlay on source.
        mode_sel = 2'd3;
        pix(1, 1, 1, 0, 0);
        pix(1, 1, 1, 5, 17);
        pix(1, 1, 1, 16, 17);
        chk_px("e_origin", 12'hFFF, 1'b1);
        chk("e_fc0", {16'd0, fc0}, 32'd5);
        chk("e_fc1", {30'd0, fc1}, 32'd1);
        pix(1, 1, 1, 7, 32);
        chk_px("e_src", 12'h51A, 1'b0);
        pix(1, 1, 1, 3, 33);
        chk_px("e_colgrid", 12'hFFF, 1'b0);
        pix(1, 1, 0, 0, 34);
        chk_px("e_rowgrid", 12'hFFF, 1'b0);
        pix(1, 1, 0, 0, 34);
        chk_px("e_src2", 12'h31C, 1'b0);

        // Frame 6 in fill, then reset mid-frame.
        mode_sel = 2'd1;
        pix(1, 1, 1, 0, 0);
        pix(1, 1, 1, 1, 0);
        pix(1, 1, 1, 2, 0);
        chk_px("f_fill", 12'h357, 1'b1);
        chk("f_fc0", {16'd0, fc0}, 32'd6);
        chk("f_fc1", {30'd0, fc1}, 32'd2);
        reset_n = 1'b0;
        #2;
        chk("f_rst_rgb", {20'd0, r0, g0, b0}, 32'h0);
        chk("f_rst_fs", {31'd0, fs0}, 32'd0);
        chk("f_rst_fc0", {16'd0, fc0}, 32'd0);
        chk("f_rst_fc1", {30'd0, fc1}, 32'd0);
        chk("f_rst_hs", {31'd0, hs0}, 32'd1);
        @(posedge pixel_clk);
        #1;
        reset_n = 1'b1;

        // Rest of the interrupted frame runs in mode 0 with no frame_start.
        pix(1, 1, 1, 3, 0);
        pix(1, 1, 1, 4, 0);
        pix(1, 1, 1, 5, 0);
        chk_px("g_c3", 12'h30C, 1'b0);
        pix(1, 1, 1, 0, 0);
        chk_px("g_c4", 12'h40B, 1'b0);
        pix(1, 1, 1, 1, 0);
        chk_px("g_c5", 12'h50A, 1'b0);
        pix(1, 1, 1, 2, 0);
        chk_px("g_f_p0", 12'h357, 1'b1);
        chk("g_fc0", {16'd0, fc0}, 32'd1);
        chk("g_fc1", {30'd0, fc1}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_output_stage.md
Name: vga_output_stage

Overview:
- Final pixel stage between the VGA timing controller, the pixel source (framebuffer/renderer) and the board VGA pins.
- Delay-matches the timing signals to a pixel source with fixed read latency.
- Forces black during blanking and selects between source video and built-in test patterns.
- Mode changes are frame-synchronous (no tearing); exports a frame counter and frame-start strobe for game logic.

Parameters:
- COLOR_BITS, 4, bits per colour channel
- COL_W, 10, column coordinate width
- ROW_W, 9, row coordinate width
- H_ACTIVE, 640, active pixels per line (used for colour bars)
- PIPE_DEPTH, 2, pixel source latency in cycles from coordinate to src_rgb; 0..8 legal
- SYNC_INVERT, 0, 1 = invert h/v sync polarity at output
- SYNC_IDLE, 1, output sync level while in reset
- GRID_LOG2, 4, grid pitch = 2^GRID_LOG2 pixels
- FC_W, 16, frame counter width

Ports:
- pixel_clk  in  1  pixel clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- h_sync_in  in  1  h_sync from timing controller
- v_sync_in  in  1  v_sync from timing controller
- disp_ena_in  in  1  active-video flag from controller
- column  in  COL_W  current pixel column
- row  in  ROW_W  current pixel row
- src_r, src_g, src_b  in  COLOR_BITS each  source pixel, valid PIPE_DEPTH cycles after its coordinate
- mode_sel  in  2  0=source, 1=solid fill, 2=colour bars, 3=source with grid overlay
- fill_rgb  in  3*COLOR_BITS  solid fill colour {R,G,B}
- vga_r, vga_g, vga_b  out  COLOR_BITS each  registered pin outputs
- vga_hs, vga_vs  out  1  registered sync outputs
- frame_start  out  1  one-cycle pulse, aligned with the first active output pixel of a frame
- frame_count  out  FC_W  completed frame-start count

Behaviour:
- Reset (async assert, sync release):
  - vga_r/g/b = 0; vga_hs = vga_vs = SYNC_IDLE; frame_start = 0; frame_count = 0; active mode = 0.
  - All delay stages cleared: disp_ena = 0, coordinates = 0, sync = SYNC_IDLE ^ SYNC_INVERT. Pins therefore hold SYNC_IDLE until real timing flushes through.
- Latency: fixed PIPE_DEPTH+1 cycles from timing/coordinate inputs to pins.
  - Input-side delay line of PIPE_DEPTH stages carries h_sync, v_sync, disp_ena, column, row and the mode tag.
  - Stage PIPE_DEPTH is combined with src_rgb, then registered into the pins.
  - PIPE_DEPTH=0: coordinates combine with same-cycle src_rgb into one output register.
- Frame start, input side: disp_ena_in=1 and column=0 and row=0.
  - On that cycle, the active mode latches mode_sel; the new mode tags that pixel onward.
  - mode_sel changes at any other time have no effect until the next frame start, so every output frame uses one mode.
- Output colour, registered:
  - Delayed disp_ena=0: all channels 0, regardless of mode.
  - Mode 0: src_rgb.
  - Mode 1: fill_rgb.
  - Mode 2: bar = col_d / (H_ACTIVE/8), clamped to 7; k = 7 - bar. Each channel is all-ones if its bit is set (R=k[2], G=k[1], B=k[0]), else 0. Bar 0 is white, bar 7 is black.
  - Mode 3: all-ones white where col_d[GRID_LOG2-1:0]=0 or row_d[GRID_LOG2-1:0]=0; elsewhere src_rgb.
- Sync: vga_hs = delayed h_sync ^ SYNC_INVERT; vga_vs likewise. Sync is never gated by disp_ena.
- frame_start: registered with the pixel it marks, high for exactly one cycle. frame_count increments on the same edge and wraps from 2^FC_W-1 to 0.
- Reset mid-frame: outputs return to reset values immediately. After release, mode 0 is used until the next frame start; no partial-frame frame_start pulse is generated.
- Simultaneous mode_sel change on the frame-start cycle: the new value is taken.

Test Plan:
- Reset then PIPE_DEPTH=2, mode 0, src model returning src_r=column[3:0] with 2-cycle latency → vga_r at col 5 appears exactly 3 cycles after column=5 is driven, value 5; vga_hs edges trail h_sync_in edges by 3 cycles.
- Mode 0 during blanking (disp_ena_in=0) with src_rgb=F,F,F → vga_r/g/b = 0 throughout blanking; sync still toggles.
- Mode 2, H_ACTIVE=640 → col 0..79 = F,F,F; col 80..159 = F,F,0; col 560..639 = 0,0,0.
- mode_sel 0→1 asserted at row 100 mid-frame, fill_rgb=3,5,7 → rest of frame stays source video; from the next frame's pixel (0,0) the output is 3,5,7; frame_start pulses once there.
- SYNC_INVERT=1, reset asserted → vga_hs = vga_vs = SYNC_IDLE. After release, pins equal the inverted controller syncs after 3 cycles.
- FC_W=2, run 5 frames → frame_count sequence 1,2,3,0,1; reset asserted mid-frame → frame_count=0 and rgb=0 asynchronously.
